// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=7, rate-1/2 hard-decision Viterbi decoder.
// Holds the code constants, the default generator masks, the path-metric type
// and the branch-output helper used to build the 64-state trellis.
package viterbi_pkg;

  localparam int K            = 7;
  localparam int NSTATES      = 64;
  localparam int SW           = 6;
  localparam int PM_W_DEFAULT = 8;

  localparam logic [6:0] G1_DEFAULT = 7'b1101011;
  localparam logic [6:0] G0_DEFAULT = 7'b0011111;

  typedef logic [PM_W_DEFAULT-1:0] pm_t;

  // Encoder output {c1,c0} for predecessor state p and input bit u (r[0] = u).
  function automatic logic [1:0] branch_out(input logic [5:0] p, input logic u,
                                            input logic [6:0] g1, input logic [6:0] g0);
    logic [6:0] r;
    r = {p, u};
    return {^(r & g1), ^(r & g0)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select cell for one destination trellis state.
// Receives both candidate metrics (predecessor metric plus branch metric) and the
// predecessor survivors, picks the smaller candidate (b=0 on a tie) and extends
// the winning survivor with this step's input bit.
module viterbi_acs #(
  parameter int PM_W     = 8,
  parameter int TB_DEPTH = 32
) (
  input  logic [PM_W-1:0]     cand0,
  input  logic [PM_W-1:0]     cand1,
  input  logic [TB_DEPTH-2:0] surv0,
  input  logic [TB_DEPTH-2:0] surv1,
  input  logic                u,
  output logic [PM_W-1:0]     pm_win,
  output logic [TB_DEPTH-1:0] surv_win,
  output logic                msb
);

  logic pick1;

  assign pick1    = (cand1 < cand0);
  assign pm_win   = pick1 ? cand1 : cand0;
  assign surv_win = {(pick1 ? surv1 : surv0), u};
  assign msb      = pm_win[PM_W-1];

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder, rate 1/2, K=7 (64 states).
// One coded symbol in and (once the survivors are full) one decoded bit out per
// accepted beat, TB_DEPTH symbols behind the input.
// Optional build macro VITERBI_PM_OUT_EN adds best_pm and norm_evt outputs.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int         TB_DEPTH = 32,
  parameter int         PM_W     = PM_W_DEFAULT,
  parameter logic [6:0] G1       = G1_DEFAULT,
  parameter logic [6:0] G0       = G0_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [1:0]      in_sym,
  output logic            out_valid,
`ifdef VITERBI_PM_OUT_EN
  output logic [PM_W-1:0] best_pm,
  output logic            norm_evt,
`endif
  output logic            out_bit
);

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]   PM_INIT  = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);

  logic [PM_W-1:0]     pm       [NSTATES];
  logic [TB_DEPTH-1:0] surv     [NSTATES];
  logic [PM_W-1:0]     pm_win   [NSTATES];
  logic [TB_DEPTH-1:0] surv_win [NSTATES];
  logic [NSTATES-1:0]  msb;
  logic                all_msb;
  logic                accept;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_next;
  logic [SW-1:0]       best;

  logic [SW-1:0]       tree_idx [1:2*NSTATES-1];
  logic [PM_W-1:0]     tree_pm  [1:2*NSTATES-1];

  assign accept    = in_valid & ~flush;
  assign all_msb   = &msb;
  assign fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;

  // One ACS cell per destination state s'; predecessors are {b, s'[5:1]}.
  for (genvar s = 0; s < NSTATES; s++) begin : g_acs
    localparam logic [5:0] P0 = {1'b0, 5'(s / 2)};
    localparam logic [5:0] P1 = {1'b1, 5'(s / 2)};
    localparam logic       U  = 1'(s % 2);
    localparam logic [1:0] C0 = branch_out(P0, U, G1, G0);
    localparam logic [1:0] C1 = branch_out(P1, U, G1, G0);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = hamming2(in_sym, C0);
    assign bm1 = hamming2(in_sym, C1);

    viterbi_acs #(
      .PM_W    (PM_W),
      .TB_DEPTH(TB_DEPTH)
    ) u_acs (
      .cand0   (pm[P0] + PM_W'(bm0)),
      .cand1   (pm[P1] + PM_W'(bm1)),
      .surv0   (surv[P0][TB_DEPTH-2:0]),
      .surv1   (surv[P1][TB_DEPTH-2:0]),
      .u       (U),
      .pm_win  (pm_win[s]),
      .surv_win(surv_win[s]),
      .msb     (msb[s])
    );
  end

  // Binary min tree over the registered metrics; left subtree wins ties so the lowest index is kept.
  always_comb begin
    for (int i = 0; i < NSTATES; i++) begin
      tree_idx[NSTATES+i] = SW'(i);
      tree_pm[NSTATES+i]  = pm[i];
    end
    for (int n = NSTATES - 1; n >= 1; n--) begin
      if (tree_pm[2*n+1] < tree_pm[2*n]) begin
        tree_idx[n] = tree_idx[2*n+1];
        tree_pm[n]  = tree_pm[2*n+1];
      end else begin
        tree_idx[n] = tree_idx[2*n];
        tree_pm[n]  = tree_pm[2*n];
      end
    end
  end

  assign best    = tree_idx[1];
  assign out_bit = surv[best][TB_DEPTH-1];
`ifdef VITERBI_PM_OUT_EN
  assign best_pm = tree_pm[1];
`endif

  // Trellis state, fill count and output strobe; flush restarts the frame exactly like reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSTATES; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_INIT;
        surv[s] <= '0;
      end
      fill      <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      for (int s = 0; s < NSTATES; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_INIT;
        surv[s] <= '0;
      end
      fill      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept && (fill_next == FILL_MAX);
      if (accept) begin
        for (int s = 0; s < NSTATES; s++) begin
          pm[s]   <= all_msb ? {1'b0, pm_win[s][PM_W-2:0]} : pm_win[s];
          surv[s] <= surv_win[s];
        end
        fill <= fill_next;
      end
    end
  end

`ifdef VITERBI_PM_OUT_EN
  // One-cycle pulse after every accepted beat that normalised the metrics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      norm_evt <= 1'b0;
    end else if (flush) begin
      norm_evt <= 1'b0;
    end else begin
      norm_evt <= accept & all_msb;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: a reference K=7 encoder feeds the
// decoder, expected data bits are queued as each symbol is accepted and popped
// whenever the decoder raises out_valid.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 32;
  localparam int PM_W     = 8;
  localparam logic [6:0] REF_G1 = 7'b1101011;
  localparam logic [6:0] REF_G0 = 7'b0011111;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            flush    = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0]      in_sym   = 2'b00;
  logic            out_valid;
  logic            out_bit;
`ifdef VITERBI_PM_OUT_EN
  logic [PM_W-1:0] best_pm;
  logic            norm_evt;
`endif

  typedef struct {
    bit chk;
    bit val;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp     = 0;
  int         n_fail    = 0;
  int         fill_m    = 0;
  int         norm_seen = 0;
  logic [5:0] enc_sr    = '0;

  always #5 clk = ~clk;

  viterbi_decoder #(
    .TB_DEPTH(TB_DEPTH),
    .PM_W    (PM_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_sym   (in_sym),
    .out_valid(out_valid),
`ifdef VITERBI_PM_OUT_EN
    .best_pm  (best_pm),
    .norm_evt (norm_evt),
`endif
    .out_bit  (out_bit)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference encoder: enc_sr[0] is the previous bit, enc_sr[5] the oldest.
  task automatic encodeBit(input logic u, output logic [1:0] sym);
    logic [6:0] r;
    r      = {enc_sr, u};
    sym    = {^(r & REF_G1), ^(r & REF_G0)};
    enc_sr = {enc_sr[4:0], u};
  endtask

  task automatic checkOutput(input logic exp_ov);
    exp_t e;
    n_cmp++;
    assert (out_valid === exp_ov) else begin
      n_fail++;
      $error("[TB] FAIL out_valid: observed %b expected %b", out_valid, exp_ov);
    end
    if (exp_ov && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("[TB] FAIL scoreboard: output seen with empty queue");
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          n_cmp++;
          assert (out_bit === e.val) else begin
            n_fail++;
            $error("[TB] FAIL out_bit: observed %b expected %b", out_bit, e.val);
          end
        end
      end
    end
`ifdef VITERBI_PM_OUT_EN
    if (norm_evt === 1'b1) norm_seen++;
`endif
  endtask

  task automatic applyStimulus(input logic f, input logic v, input logic [1:0] sym,
                               input bit chk, input bit val);
    exp_t e;
    logic exp_ov;
    @(negedge clk);
    flush    = f;
    in_valid = v;
    in_sym   = sym;
    @(posedge clk);
    #1;
    if (f) begin
      fill_m = 0;
      exp_q.delete();
      exp_ov = 1'b0;
    end else if (v) begin
      e.chk = chk;
      e.val = val;
      exp_q.push_back(e);
      if (fill_m < TB_DEPTH) fill_m++;
      exp_ov = (fill_m >= TB_DEPTH);
    end else begin
      exp_ov = 1'b0;
    end
    checkOutput(exp_ov);
  endtask

  task automatic sendBit(input logic u, input bit chk, input logic [1:0] flip);
    logic [1:0] sym;
    encodeBit(u, sym);
    applyStimulus(1'b0, 1'b1, sym ^ flip, chk, u);
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    enc_sr = '0;
  endtask

  task automatic checkResetState(input string tag);
    n_cmp++;
    assert (out_valid === 1'b0) else begin
      n_fail++;
      $error("[TB] FAIL %s out_valid: observed %b expected 0", tag, out_valid);
    end
    n_cmp++;
    assert (out_bit === 1'b0) else begin
      n_fail++;
      $error("[TB] FAIL %s out_bit: observed %b expected 0", tag, out_bit);
    end
`ifdef VITERBI_PM_OUT_EN
    n_cmp++;
    assert (best_pm === '0) else begin
      n_fail++;
      $error("[TB] FAIL %s best_pm: observed %0d expected 0", tag, best_pm);
    end
`endif
  endtask

  initial begin
    logic u;
    logic [1:0] flip;

    $display("[TB] reset and all-zero stream");
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b1;
    enc_sr = '0;
    for (int i = 0; i < 100; i++) sendBit(1'b0, 1'b1, 2'b00);
`ifdef VITERBI_PM_OUT_EN
    n_cmp++;
    assert (best_pm === '0) else begin
      n_fail++;
      $error("[TB] FAIL zero_stream best_pm: observed %0d expected 0", best_pm);
    end
`endif

    $display("[TB] clean random frame");
    startFrame();
    for (int i = 0; i < 500; i++) sendBit(1'($urandom_range(0, 1)), 1'b1, 2'b00);

    $display("[TB] random frame with one symbol bit error every 20 symbols");
    startFrame();
    for (int i = 0; i < 500; i++) begin
      flip = (i % 20 == 7) ? (((i / 20) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      sendBit(1'($urandom_range(0, 1)), 1'b1, flip);
    end

    $display("[TB] long random symbol run, then lock onto a clean stream");
    for (int i = 0; i < 5000; i++)
      applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    enc_sr = 6'($urandom_range(0, 63));
    for (int i = 0; i < 200; i++) sendBit(1'($urandom_range(0, 1)), (i >= 80), 2'b00);
`ifdef VITERBI_PM_OUT_EN
    n_cmp++;
    assert (norm_seen > 0) else begin
      n_fail++;
      $error("[TB] FAIL norm_evt: observed %0d pulses expected at least 1", norm_seen);
    end
`endif

    $display("[TB] flush at beat 50");
    startFrame();
    for (int i = 0; i < 50; i++) sendBit(1'($urandom_range(0, 1)), 1'b1, 2'b00);
    startFrame();
    for (int i = 0; i < 150; i++) sendBit(1'($urandom_range(0, 1)), 1'b1, 2'b00);

    $display("[TB] gapped input then reset mid-stream");
    startFrame();
    for (int i = 0; i < 300; i++) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++)
        applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      u = 1'($urandom_range(0, 1));
      sendBit(u, 1'b1, 2'b00);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("mid_reset");
    fill_m = 0;
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("held_reset");
    @(negedge clk);
    rst = 1'b1;
    enc_sr = '0;
    for (int i = 0; i < 60; i++) sendBit(1'($urandom_range(0, 1)), 1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
